// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, registers instructions into a valid/ready slot,
// applies branch redirects, and detects end-of-program and misaligned targets.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] IMEM_BYTES = 64'd64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [63:0] fetch_pc,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        halted,
    output logic        fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] fpc_q, fpc_d;
    logic        slot_free;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] rcnt_q, rcnt_d;
`endif

    assign slot_free = !valid_q || fetch_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        fpc_d   = fpc_q;
`ifdef FETCH_PERF_CNT_EN
        fcnt_d  = fcnt_q;
        rcnt_d  = rcnt_q;
        if (state_q != FAULT && valid_q && fetch_ready) begin
            fcnt_d = fcnt_q + 32'd1;
        end
`endif
        case (state_q)
            IDLE: state_d = RUN;
            RUN, HALT: begin
                // Redirect wins over capture and halt detection; the slot is flushed either way.
                if (branch_taken) begin
                    valid_d = 1'b0;
                    if (branch_target[1:0] == 2'b00) begin
                        pc_d    = branch_target;
                        state_d = RUN;
`ifdef FETCH_PERF_CNT_EN
                        rcnt_d  = rcnt_q + 32'd1;
`endif
                    end else begin
                        state_d = FAULT;
                    end
                end else if (state_q == RUN && slot_free) begin
                    if (pc_q < IMEM_BYTES) begin
                        instr_d = imem_instr;
                        fpc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 64'd4;
                    end else begin
                        valid_d = 1'b0;
                        state_d = HALT;
                    end
                end
            end
            FAULT: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            fpc_q   <= '0;
`ifdef FETCH_PERF_CNT_EN
            fcnt_q  <= '0;
            rcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
`ifdef FETCH_PERF_CNT_EN
            fcnt_q  <= fcnt_d;
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign imem_addr   = pc_q;
    assign fetch_valid = valid_q;
    assign fetch_instr = instr_q;
    assign fetch_pc    = fpc_q;
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);
`ifdef FETCH_PERF_CNT_EN
    assign perf_fetch_cnt    = fcnt_q;
    assign perf_redirect_cnt = rcnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed steps then random ready/branch traffic against a
// cycle-level behavioural model. Honours FETCH_PERF_CNT_EN when defined.
module tb_fetch_sequencer;

    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam logic [63:0] IMEM_BYTES = 64'd64;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [63:0] fetch_pc;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        halted;
    logic        fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .IMEM_BYTES(IMEM_BYTES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halted       (halted),
        .fault        (fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    // 16-word program image; out-of-range or misaligned reads return a nop.
    logic [31:0] mem [16];

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a < 64'd64 && a[1:0] == 2'b00) return mem[a[5:2]];
        return 32'h0000_0013;
    endfunction

    always_comb imem_instr = word_at(imem_addr);

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model
    logic        m_started, m_valid, m_halted, m_fault;
    logic [63:0] m_pc, m_fpc;
    logic [31:0] m_instr, m_fcnt, m_rcnt;

    task automatic m_reset();
        m_started = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
        m_pc = RESET_PC; m_fpc = '0; m_instr = '0; m_fcnt = '0; m_rcnt = '0;
    endtask

    task automatic model_step(input logic rdy, input logic br, input logic [63:0] tgt);
        if (m_fault) return;
        if (!m_started) begin
            m_started = 1'b1;
            return;
        end
        if (m_valid && rdy) m_fcnt = m_fcnt + 1;
        if (br) begin
            m_valid  = 1'b0;
            m_halted = 1'b0;
            if (tgt % 4 == 0) begin
                m_pc   = tgt;
                m_rcnt = m_rcnt + 1;
            end else begin
                m_fault = 1'b1;
            end
            return;
        end
        if (m_halted) return;
        if (m_valid && !rdy) return;
        if (m_pc < IMEM_BYTES) begin
            m_instr = word_at(m_pc);
            m_fpc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
        end else begin
            m_valid  = 1'b0;
            m_halted = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fetch_valid", {63'd0, fetch_valid}, {63'd0, m_valid});
        chk("fetch_instr", {32'd0, fetch_instr}, {32'd0, m_instr});
        chk("fetch_pc", fetch_pc, m_fpc);
        chk("imem_addr", imem_addr, m_pc);
        chk("halted", {63'd0, halted}, {63'd0, m_halted});
        chk("fault", {63'd0, fault}, {63'd0, m_fault});
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt", {32'd0, perf_fetch_cnt}, {32'd0, m_fcnt});
        chk("perf_redirect_cnt", {32'd0, perf_redirect_cnt}, {32'd0, m_rcnt});
`endif
    endtask

    task automatic cycle(input logic rdy, input logic br, input logic [63:0] tgt);
        fetch_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        model_step(rdy, br, tgt);
        #1;
        check_all();
        branch_taken = 1'b0;
    endtask

    // Asserted off-edge; outputs must clear before the next rising edge.
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        m_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] tgt;
        int          fault_age;
        for (int unsigned i = 0; i < 16; i++) mem[i] = 32'h0010_0093 + (i << 20);
        mem[0]  = 32'h01600bb3;
        mem[2]  = 32'h00062783;
        mem[4]  = 32'h00a186b3;
        mem[15] = 32'hfcbb12e3;

        reset = 1'b1; fetch_ready = 1'b1; branch_taken = 1'b0; branch_target = '0;
        apply_reset();
        chk("reset_addr", imem_addr, RESET_PC);

        // Full program, no stalls
        cycle(1'b1, 1'b0, '0);
        chk("idle_no_valid", {63'd0, fetch_valid}, 64'd0);
        cycle(1'b1, 1'b0, '0);
        chk("first_pc", fetch_pc, 64'd0);
        chk("first_instr", {32'd0, fetch_instr}, 64'h01600bb3);
        for (int unsigned i = 0; i < 15; i++) cycle(1'b1, 1'b0, '0);
        chk("last_pc", fetch_pc, 64'd60);
        chk("last_instr", {32'd0, fetch_instr}, 64'hfcbb12e3);
        cycle(1'b1, 1'b0, '0);
        chk("halt_flag", {63'd0, halted}, 64'd1);
        chk("halt_valid", {63'd0, fetch_valid}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_full_prog", {32'd0, perf_fetch_cnt}, 64'd16);
`endif
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);

        // Redirect out of HALT
        cycle(1'b1, 1'b1, 64'd4);
        chk("halt_exit", {63'd0, halted}, 64'd0);
        cycle(1'b1, 1'b0, '0);
        chk("halt_redirect_pc", fetch_pc, 64'd4);
        cycle(1'b1, 1'b0, '0);

        // Stall holding pc 8
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0);
            chk("stall_pc", fetch_pc, 64'd8);
            chk("stall_instr", {32'd0, fetch_instr}, 64'h00062783);
            chk("stall_addr", imem_addr, 64'd12);
        end
        cycle(1'b1, 1'b0, '0);
        chk("resume_pc", fetch_pc, 64'd12);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
        chk("pre_branch_pc", fetch_pc, 64'd28);

        // Redirect with one bubble
        cycle(1'b1, 1'b1, 64'd16);
        chk("bubble", {63'd0, fetch_valid}, 64'd0);
        cycle(1'b1, 1'b0, '0);
        chk("target_pc", fetch_pc, 64'd16);
        chk("target_instr", {32'd0, fetch_instr}, 64'h00a186b3);

        // Misaligned target -> sticky FAULT
        cycle(1'b1, 1'b1, 64'd6);
        chk("fault_set", {63'd0, fault}, 64'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 64'd0);
            chk("fault_sticky", {63'd0, fault}, 64'd1);
        end
        apply_reset();
        chk("fault_cleared", {63'd0, fault}, 64'd0);

        // Async reset mid-run
        for (int unsigned i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);
        apply_reset();

        // Randomised traffic
        fault_age = 0;
        for (int unsigned i = 0; i < 400; i++) begin
            logic rdy, br;
            rdy = ($urandom_range(0, 99) < 70);
            br  = ($urandom_range(0, 99) < 6);
            tgt = 64'(4 * $urandom_range(0, 20));
            if ($urandom_range(0, 99) < 8) tgt = tgt + 64'($urandom_range(1, 3));
            cycle(rdy, br, tgt);
            if (m_fault) begin
                fault_age++;
                if (fault_age > 3) begin
                    apply_reset();
                    fault_age = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
